// File: rtl/brisc_pkg.sv
// Shared types for the memory-side blocks of the core.
// Arbiter FSM states and grant identifiers.
package brisc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } arb_port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker.
// last_grant only moves when the caller accepts the grant.
module rr_arbiter2
    import brisc_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_ic,
    input  logic req_dc,
    input  logic take,
    output logic any,
    output logic grant_dc
);

    arb_port_e last_grant;

    // Pick a winner; on contention favour the port not granted last.
    always_comb begin
        any      = req_ic | req_dc;
        grant_dc = 1'b0;
        if (req_ic && req_dc) begin
            grant_dc = (last_grant == IC);
        end else if (req_dc) begin
            grant_dc = 1'b1;
        end
    end

    // Remember who won the last accepted grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IC;
        end else if (take && any) begin
            last_grant <= grant_dc ? DC : IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache/dcache requests onto the single memory port.
// One outstanding line fill, guarded by a saturating watchdog.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDRESS_WIDTH      = 32,
    parameter int FILL_DATA_WIDTH    = 128,
    parameter int WORD_WIDTH         = 32,
    parameter int DATA_TRANSFER_TIME = 5,
    parameter int TIMEOUT            = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ic_req,
    input  logic [ADDRESS_WIDTH-1:0]   ic_addr,
    output logic                       ic_ready,
    output logic                       ic_fill_valid,
    output logic [FILL_DATA_WIDTH-1:0] ic_fill_data,
    input  logic                       dc_req,
    input  logic                       dc_store,
    input  logic                       dc_store_word,
    input  logic [ADDRESS_WIDTH-1:0]   dc_addr,
    input  logic [WORD_WIDTH-1:0]      dc_wdata,
    output logic                       dc_ready,
    output logic                       dc_fill_valid,
    output logic [FILL_DATA_WIDTH-1:0] dc_fill_data,
    output logic                       mem_req,
    output logic                       mem_store,
    output logic                       mem_store_word,
    output logic [ADDRESS_WIDTH-1:0]   mem_address,
    output logic [WORD_WIDTH-1:0]      mem_evict_data,
    input  logic [FILL_DATA_WIDTH-1:0] mem_fill_data,
    input  logic                       mem_response_valid,
    output logic                       timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e           state;
    arb_state_e           state_nx;
    arb_port_e            owner;
    logic [CW-1:0]        cnt;
    logic [FILL_DATA_WIDTH-1:0] resp;
    logic                 any;
    logic                 grant_dc;
    logic                 take;
    logic                 latch;
    logic                 cap;
    logic                 tmo;
    logic                 cnt_last;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_ic   (ic_req),
        .req_dc   (dc_req),
        .take     (take),
        .any      (any),
        .grant_dc (grant_dc)
    );

    assign cnt_last     = (cnt == CW'(TIMEOUT - 1));
    assign ic_fill_data = resp;
    assign dc_fill_data = resp;

    // Next state, memory command mux and handshake pulses.
    always_comb begin
        state_nx       = state;
        take           = 1'b0;
        latch          = 1'b0;
        cap            = 1'b0;
        tmo            = 1'b0;
        ic_ready       = 1'b0;
        dc_ready       = 1'b0;
        ic_fill_valid  = 1'b0;
        dc_fill_valid  = 1'b0;
        mem_req        = 1'b0;
        mem_store      = 1'b0;
        mem_store_word = 1'b0;
        mem_address    = '0;
        mem_evict_data = '0;
        unique case (state)
            IDLE: begin
                if (any && reset_n) begin
                    take    = 1'b1;
                    mem_req = 1'b1;
                    if (grant_dc) begin
                        dc_ready       = 1'b1;
                        mem_address    = dc_addr;
                        mem_store      = dc_store;
                        mem_store_word = dc_store & dc_store_word;
                        if (dc_store) begin
                            mem_evict_data = dc_wdata;
                        end else begin
                            latch    = 1'b1;
                            state_nx = WAIT;
                        end
                    end else begin
                        ic_ready    = 1'b1;
                        mem_address = ic_addr;
                        latch       = 1'b1;
                        state_nx    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_response_valid) begin
                    cap      = 1'b1;
                    state_nx = RESP;
                end else if (cnt_last) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            RESP: begin
                ic_fill_valid = (owner == IC);
                dc_fill_valid = (owner == DC);
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, fill owner, watchdog counter, error flag and line capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= IC;
            cnt         <= '0;
            timeout_err <= 1'b0;
            resp        <= '0;
        end else begin
            state <= state_nx;
            if (latch) begin
                owner <= grant_dc ? DC : IC;
                cnt   <= '0;
            end else if (state == WAIT && cnt != CW'(TIMEOUT)) begin
                cnt <= cnt + 1'b1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
            end
            if (cap) begin
                resp <= mem_fill_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory stub.
// Stub answers fills DTT cycles after issue unless muted.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int FW  = 128;
    localparam int WW  = 32;
    localparam int DTT = 5;
    localparam int TMO = 16;

    localparam logic [FW-1:0] L40  = 128'h4F4E4D4C_4B4A4948_47464544_43424140;
    localparam logic [FW-1:0] L10  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [FW-1:0] L10S = 128'h1F1E1D1C_1B1A1918_17161514_AB121110;
    localparam logic [FW-1:0] L20S = 128'h2F2E2D2C_2B2A2928_27262524_DEADBEEF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic          ic_fill_valid;
    logic [FW-1:0] ic_fill_data;
    logic          dc_req = 1'b0;
    logic          dc_store = 1'b0;
    logic          dc_store_word = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [WW-1:0] dc_wdata = '0;
    logic          dc_ready;
    logic          dc_fill_valid;
    logic [FW-1:0] dc_fill_data;
    logic          mem_req;
    logic          mem_store;
    logic          mem_store_word;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_evict_data;
    logic [FW-1:0] mem_fill_data = '0;
    logic          mem_response_valid = 1'b0;
    logic          timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int due = -1;
    bit answer = 1'b1;
    logic [7:0]    mem [0:255];
    logic [FW-1:0] line_q = '0;
    int            a;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDRESS_WIDTH      (AW),
        .FILL_DATA_WIDTH    (FW),
        .WORD_WIDTH         (WW),
        .DATA_TRANSFER_TIME (DTT),
        .TIMEOUT            (TMO)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .ic_req             (ic_req),
        .ic_addr            (ic_addr),
        .ic_ready           (ic_ready),
        .ic_fill_valid      (ic_fill_valid),
        .ic_fill_data       (ic_fill_data),
        .dc_req             (dc_req),
        .dc_store           (dc_store),
        .dc_store_word      (dc_store_word),
        .dc_addr            (dc_addr),
        .dc_wdata           (dc_wdata),
        .dc_ready           (dc_ready),
        .dc_fill_valid      (dc_fill_valid),
        .dc_fill_data       (dc_fill_data),
        .mem_req            (mem_req),
        .mem_store          (mem_store),
        .mem_store_word     (mem_store_word),
        .mem_address        (mem_address),
        .mem_evict_data     (mem_evict_data),
        .mem_fill_data      (mem_fill_data),
        .mem_response_valid (mem_response_valid),
        .timeout_err        (timeout_err)
    );

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    end

    // Memory stub: sample the command mid-cycle.
    always @(negedge clk) begin
        if (mem_req) begin
            if (mem_store) begin
                if (mem_store_word) begin
                    for (int b = 0; b < 4; b++) begin
                        a = int'(mem_address[7:0]) + b;
                        mem[a[7:0]] = mem_evict_data[8*b +: 8];
                    end
                end else begin
                    mem[mem_address[7:0]] = mem_evict_data[7:0];
                end
            end else if (answer) begin
                for (int k = 0; k < 16; k++) begin
                    a = int'({mem_address[7:4], 4'h0}) + k;
                    line_q[8*k +: 8] = mem[a[7:0]];
                end
                due = cyc + DTT;
            end
        end
    end

    // Cycle counter and response strobe, driven just after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_response_valid = (cyc == due);
        mem_fill_data = (cyc == due) ? line_q : '0;
    end

    task automatic check(input string tag, input logic [FW-1:0] got,
                         input logic [FW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fill(input bit dcp, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            #1;
            if (dcp ? dc_fill_valid : ic_fill_valid) begin
                n = k;
                break;
            end
        end
    endtask

    int  n;
    logic seen;

    initial begin
        repeat (3) @(posedge clk);
        #3;
        check("rst_cmd", {mem_req, mem_store, mem_store_word}, 0);
        check("rst_hs", {ic_ready, dc_ready, ic_fill_valid, dc_fill_valid}, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_addr", mem_address, 0);
        reset_n = 1'b1;
        step(); #1;
        check("idle_mem_req", mem_req, 0);

        // contention from reset: DC first, IC after DC's RESP
        step();
        ic_req = 1; ic_addr = 32'h40;
        dc_req = 1; dc_store = 0; dc_addr = 32'h10;
        #1;
        check("cont_dc_ready", dc_ready, 1);
        check("cont_ic_ready", ic_ready, 0);
        check("cont_addr", mem_address, 32'h10);
        check("cont_store", mem_store, 0);
        step(); #1;
        check("cont_wait_req", mem_req, 0);
        wait_fill(1, 20, n);
        check("cont_dc_lat", n, DTT);
        check("cont_dc_data", dc_fill_data, L10);
        check("cont_ic_quiet", ic_fill_valid, 0);
        dc_req = 0;
        wait_fill(0, 20, n);
        check("cont_ic_gap", n, 7);
        check("cont_ic_data", ic_fill_data, L40);
        ic_req = 0;

        // back-to-back byte and word stores, then fills
        step();
        dc_req = 1; dc_store = 1; dc_store_word = 0;
        dc_addr = 32'h13; dc_wdata = 32'h0000_00AB;
        #1;
        check("st_b_ready", dc_ready, 1);
        check("st_b_cmd", {mem_req, mem_store, mem_store_word}, 3'b110);
        check("st_b_data", mem_evict_data, 32'hAB);
        check("st_b_addr", mem_address, 32'h13);
        step();
        dc_store_word = 1; dc_addr = 32'h20; dc_wdata = 32'hDEADBEEF;
        #1;
        check("st_w_ready", dc_ready, 1);
        check("st_w_cmd", {mem_req, mem_store, mem_store_word}, 3'b111);
        check("st_w_data", mem_evict_data, 32'hDEADBEEF);
        step();
        dc_store = 0; dc_store_word = 0; dc_addr = 32'h10;
        #1;
        check("fl10_cmd", {dc_ready, mem_req, mem_store}, 3'b110);
        wait_fill(1, 20, n);
        check("fl10_lat", n, DTT + 1);
        check("fl10_data", dc_fill_data, L10S);
        dc_req = 0;
        step();
        dc_req = 1; dc_addr = 32'h20;
        #1;
        check("fl20_ready", dc_ready, 1);
        wait_fill(1, 20, n);
        check("fl20_lat", n, DTT + 1);
        check("fl20_data", dc_fill_data, L20S);
        dc_req = 0;

        // store request while an IC fill is outstanding
        step();
        ic_req = 1; ic_addr = 32'h40;
        #1;
        check("sdf_ic_ready", ic_ready, 1);
        step();
        dc_req = 1; dc_store = 1; dc_store_word = 1;
        dc_addr = 32'h30; dc_wdata = 32'h1234_5678;
        #1;
        seen = dc_ready;
        for (int k = 2; k <= 5; k++) begin
            step(); #1;
            seen = seen | dc_ready;
        end
        step(); #1;
        seen = seen | dc_ready;
        check("sdf_ic_fill", ic_fill_valid, 1);
        check("sdf_dc_blocked", seen, 0);
        ic_req = 0;
        step(); #1;
        check("sdf_dc_ready", dc_ready, 1);
        check("sdf_cmd", {mem_req, mem_store, mem_store_word}, 3'b111);
        check("sdf_addr", mem_address, 32'h30);
        step();
        dc_req = 0; dc_store = 0; dc_store_word = 0;

        // watchdog: stub stays silent
        answer = 0;
        step();
        dc_req = 1; dc_addr = 32'h50;
        #1;
        check("wd_issue", dc_ready, 1);
        seen = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            step(); #1;
            seen = seen | timeout_err;
            if (k == TMO) dc_req = 0;
        end
        check("wd_early", seen, 0);
        step(); #1;
        check("wd_tmo", timeout_err, 1);
        check("wd_no_fill", dc_fill_valid, 0);
        check("wd_idle_req", mem_req, 0);
        answer = 1;
        step();
        ic_req = 1; ic_addr = 32'h40;
        #1;
        check("wd_next_ready", ic_ready, 1);
        wait_fill(0, 20, n);
        check("wd_next_lat", n, DTT + 1);
        check("wd_next_data", ic_fill_data, L40);
        check("wd_sticky", timeout_err, 1);
        ic_req = 0;

        // reset while waiting; late response must be dropped
        step();
        ic_req = 1; ic_addr = 32'h40;
        #1;
        check("rw_issue", ic_ready, 1);
        step();
        step();
        reset_n = 0; ic_req = 0;
        #1;
        check("rw_outs", {mem_req, mem_store, mem_store_word, ic_ready,
                          dc_ready, ic_fill_valid, dc_fill_valid,
                          timeout_err}, 0);
        check("rw_line", ic_fill_data, 0);
        step();
        reset_n = 1;
        seen = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            step(); #1;
            seen = seen | ic_fill_valid | dc_fill_valid | mem_req;
        end
        check("rw_no_fill", seen, 0);
        check("rw_final", {ic_fill_data, timeout_err, mem_address}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
